password_validator_n: RTL and testbench

//  Parametrised serial password checker for the lock panel: takes one digit per enable

---
 rtl/password_validator_n.sv | 177 +++++++++++++++++
 tb/tb_password_validator_n.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/password_validator_n.sv
// Serial password checker for the lock panel. It takes one digit per enable
// strobe and compares the entry against the external password RAM and a fixed
// admin code. It counts consecutive failures into a timed lockout, and from
// UNLOCK it can program a new password into the RAM.
module password_validator_n #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_CODE = 16'h9210,
    localparam int IDX_W = $clog2(DIGITS),
    localparam int FC_W  = $clog2(MAX_FAIL+1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic               prog_req,
    input  logic               admin_reset,
    output logic [IDX_W-1:0]   rd_addr,
    input  logic [DIGIT_W-1:0] rd_data,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_addr,
    output logic [DIGIT_W-1:0] wr_data,
    output logic               unlock_light,
    output logic               admin_light,
    output logic               error_light,
    output logic               lock_down,
    output logic [FC_W-1:0]    fail_count
);

    localparam int LC_W = $clog2(LOCK_CYCLES+1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DIGITS-1);
    localparam logic [FC_W-1:0]  FC_MAX      = FC_W'(MAX_FAIL);
    localparam logic [FC_W-1:0]  FC_RELEASE  = FC_W'(MAX_FAIL-1);
    localparam logic [LC_W-1:0]  LC_LAST     = LC_W'(LOCK_CYCLES-1);

    typedef enum logic [2:0] {ENTRY, UNLOCK, ERROR, LOCK, PROG} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               user_bad, user_bad_n, adm_bad, adm_bad_n;
    logic               user_acc, adm_acc;
    logic               admin_flag, admin_flag_n;
    logic [FC_W-1:0]    fail_n;
    logic [LC_W-1:0]    lock_cnt, lock_cnt_n;
    logic               wr_en_n;
    logic [IDX_W-1:0]   wr_addr_n;
    logic [DIGIT_W-1:0] wr_data_n;

    // Registered state, entry progress, failure/lock counters and RAM write port
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ENTRY;
            idx        <= '0;
            user_bad   <= 1'b0;
            adm_bad    <= 1'b0;
            admin_flag <= 1'b0;
            fail_count <= '0;
            lock_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            user_bad   <= user_bad_n;
            adm_bad    <= adm_bad_n;
            admin_flag <= admin_flag_n;
            fail_count <= fail_n;
            lock_cnt   <= lock_cnt_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
        end
    end

    // Next-state decode; mismatch flags accumulate so a verdict sees the final digit too
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        user_bad_n   = user_bad;
        adm_bad_n    = adm_bad;
        admin_flag_n = admin_flag;
        fail_n       = fail_count;
        lock_cnt_n   = '0;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        user_acc     = user_bad | (digit != rd_data);
        adm_acc      = adm_bad  | (digit != ADMIN_CODE[int'(idx)*DIGIT_W +: DIGIT_W]);

        if (admin_reset) begin
            state_n      = ENTRY;
            idx_n        = '0;
            user_bad_n   = 1'b0;
            adm_bad_n    = 1'b0;
            admin_flag_n = 1'b0;
            fail_n       = '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (enable) begin
                        if (idx == LAST_IDX) begin
                            idx_n      = '0;
                            user_bad_n = 1'b0;
                            adm_bad_n  = 1'b0;
                            if (!user_acc) begin
                                state_n      = UNLOCK;
                                admin_flag_n = 1'b0;
                                fail_n       = '0;
                            end else if (!adm_acc) begin
                                state_n      = UNLOCK;
                                admin_flag_n = 1'b1;
                                fail_n       = '0;
                            end else if (fail_count >= FC_RELEASE) begin
                                state_n = LOCK;
                                fail_n  = FC_MAX;
                            end else begin
                                state_n = ERROR;
                                fail_n  = fail_count + 1'b1;
                            end
                        end else begin
                            idx_n      = idx + 1'b1;
                            user_bad_n = user_acc;
                            adm_bad_n  = adm_acc;
                        end
                    end
                end
                UNLOCK: begin
                    if (clear) begin
                        state_n = ENTRY;
                    end else if (prog_req) begin
                        state_n = PROG;
                        idx_n   = '0;
                    end
                end
                ERROR: begin
                    if (clear) state_n = ENTRY;
                end
                LOCK: begin
                    if (lock_cnt == LC_LAST) begin
                        state_n = ENTRY;
                        fail_n  = FC_RELEASE;
                    end else begin
                        lock_cnt_n = lock_cnt + 1'b1;
                    end
                end
                PROG: begin
                    if (clear) begin
                        state_n = ENTRY;
                        idx_n   = '0;
                    end else if (enable) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = idx;
                        wr_data_n = digit;
                        if (idx == LAST_IDX) begin
                            state_n = ENTRY;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                default: state_n = ENTRY;
            endcase
        end
    end

    assign rd_addr      = (state == ENTRY) ? idx : '0;
    assign unlock_light = (state == UNLOCK);
    assign admin_light  = (state == UNLOCK) && admin_flag;
    assign error_light  = (state == ERROR);
    assign lock_down    = (state == LOCK);

endmodule

// File: tb/tb_password_validator_n.sv
// Directed bench for password_validator_n with a behavioural password RAM.
`timescale 1ns/1ps
module tb_password_validator_n;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enable = 1'b0, clear = 1'b0, prog_req = 1'b0, admin_reset = 1'b0;
    logic [3:0] digit = 4'h0;
    logic [1:0] rd_addr, wr_addr;
    logic [3:0] rd_data, wr_data;
    logic       wr_en, unlock_light, admin_light, error_light, lock_down;
    logic [1:0] fail_count;
    logic       load_ram = 1'b1;
    logic [3:0] ram [0:3];
    int         n_checks = 0;
    int         n_fail = 0;

    password_validator_n dut (
        .CLK(CLK), .RST(RST), .enable(enable), .digit(digit), .clear(clear),
        .prog_req(prog_req), .admin_reset(admin_reset), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .unlock_light(unlock_light), .admin_light(admin_light),
        .error_light(error_light), .lock_down(lock_down), .fail_count(fail_count)
    );

    always #5 CLK = ~CLK;

    // Password RAM: combinational read, written by the DUT write port
    always @(posedge CLK) begin
        if (load_ram) begin
            ram[0] <= 4'h1; ram[1] <= 4'h2; ram[2] <= 4'h3; ram[3] <= 4'h4;
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end
    assign rd_data = ram[rd_addr];

    wire [3:0] lights = {unlock_light, admin_light, error_light, lock_down};

    task automatic key(input logic [3:0] d);
        @(negedge CLK); enable = 1'b1; digit = d;
        @(negedge CLK); enable = 1'b0;
    endtask

    task automatic key4(input logic [3:0] a, b, c, d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic pulse_clear();
        @(negedge CLK); clear = 1'b1;
        @(negedge CLK); clear = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (lights !== 4'b0000) begin n_fail++; $display("FAIL reset_lights: got %b want 0000", lights); end
        n_checks++; if (fail_count !== 2'd0) begin n_fail++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (rd_addr !== 2'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        RST = 1'b1;
        load_ram = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_user_unlock();
        key(4'h1); key(4'h2);
        n_checks++; if (rd_addr !== 2'd2) begin n_fail++; $display("FAIL entry_rd_addr: got %0d want 2", rd_addr); end
        key(4'h3); key(4'h4);
        n_checks++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL user_unlock_lights: got %b want 1000", lights); end
        n_checks++; if (fail_count !== 2'd0) begin n_fail++; $display("FAIL user_unlock_fail_count: got %0d want 0", fail_count); end
        key4(4'h0, 4'h0, 4'h0, 4'h0);
        n_checks++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL unlock_ignores_enable: got %b want 1000", lights); end
        pulse_clear();
        n_checks++; if (lights !== 4'b0000) begin n_fail++; $display("FAIL unlock_clear: got %b want 0000", lights); end
    endtask

    task automatic test_error();
        key4(4'h1, 4'h2, 4'h3, 4'h5);
        n_checks++; if (lights !== 4'b0010) begin n_fail++; $display("FAIL error_lights: got %b want 0010", lights); end
        n_checks++; if (fail_count !== 2'd1) begin n_fail++; $display("FAIL error_fail_count: got %0d want 1", fail_count); end
        key4(4'h1, 4'h2, 4'h3, 4'h4);
        n_checks++; if (lights !== 4'b0010) begin n_fail++; $display("FAIL error_ignores_enable: got %b want 0010", lights); end
        pulse_clear();
        n_checks++; if (lights !== 4'b0000 || fail_count !== 2'd1) begin n_fail++; $display("FAIL error_clear: got %b/%0d want 0000/1", lights, fail_count); end
    endtask

    task automatic test_lock();
        key4(4'h0, 4'h0, 4'h0, 4'h0);
        n_checks++; if (lights !== 4'b0010 || fail_count !== 2'd2) begin n_fail++; $display("FAIL second_fail: got %b/%0d want 0010/2", lights, fail_count); end
        pulse_clear();
        key4(4'h0, 4'h0, 4'h0, 4'h0);
        n_checks++; if (lights !== 4'b0001) begin n_fail++; $display("FAIL lock_entered: got %b want 0001", lights); end
        n_checks++; if (fail_count !== 2'd3) begin n_fail++; $display("FAIL lock_fail_count: got %0d want 3", fail_count); end
        // 999 more edges keep LOCK; inputs wiggled early must be ignored
        for (int i = 1; i <= 999; i++) begin
            @(negedge CLK);
            if (i <= 20) begin
                enable = 1'b1; digit = 4'h1; clear = i[0]; prog_req = ~i[0];
            end else begin
                enable = 1'b0; clear = 1'b0; prog_req = 1'b0;
            end
        end
        n_checks++; if (lights !== 4'b0001) begin n_fail++; $display("FAIL lock_held_999: got %b want 0001", lights); end
        @(negedge CLK);
        n_checks++; if (lights !== 4'b0000) begin n_fail++; $display("FAIL lock_release: got %b want 0000", lights); end
        n_checks++; if (fail_count !== 2'd2) begin n_fail++; $display("FAIL lock_release_fail_count: got %0d want 2", fail_count); end
        key4(4'h5, 4'h5, 4'h5, 4'h5);
        n_checks++; if (lights !== 4'b0001) begin n_fail++; $display("FAIL relock: got %b want 0001", lights); end
        @(negedge CLK); admin_reset = 1'b1;
        @(negedge CLK); admin_reset = 1'b0;
        n_checks++; if (lights !== 4'b0000 || fail_count !== 2'd0) begin n_fail++; $display("FAIL admin_reset_lock: got %b/%0d want 0000/0", lights, fail_count); end
    endtask

    task automatic test_admin();
        key4(4'h0, 4'h1, 4'h2, 4'h9);
        n_checks++; if (lights !== 4'b1100) begin n_fail++; $display("FAIL admin_unlock: got %b want 1100", lights); end
        n_checks++; if (fail_count !== 2'd0) begin n_fail++; $display("FAIL admin_fail_count: got %0d want 0", fail_count); end
        pulse_clear();
        n_checks++; if (lights !== 4'b0000) begin n_fail++; $display("FAIL admin_clear: got %b want 0000", lights); end
    endtask

    task automatic test_prog();
        key4(4'h1, 4'h2, 4'h3, 4'h4);
        @(negedge CLK); prog_req = 1'b1;
        @(negedge CLK); prog_req = 1'b0;
        n_checks++; if (lights !== 4'b0000) begin n_fail++; $display("FAIL prog_entered: got %b want 0000", lights); end
        for (int i = 0; i < 4; i++) begin
            key(4'h7);
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 2'(i) || wr_data !== 4'h7) begin
                n_fail++; $display("FAIL prog_write_%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=7", i, wr_en, wr_addr, wr_data, i);
            end
        end
        @(negedge CLK);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL prog_wr_en_single: got %b want 0", wr_en); end
        key4(4'h7, 4'h7, 4'h7, 4'h7);
        n_checks++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL prog_new_password: got %b want 1000", lights); end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        @(negedge CLK); enable = 1'b1; digit = 4'h7;
        repeat (4) @(negedge CLK);
        enable = 1'b0;
        n_checks++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL back_to_back: got %b want 1000", lights); end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        key4(4'h1, 4'h1, 4'h1, 4'h1);
        n_checks++; if (lights !== 4'b0010 || fail_count !== 2'd1) begin n_fail++; $display("FAIL pre_reset_error: got %b/%0d want 0010/1", lights, fail_count); end
        pulse_clear();
        key(4'h7); key(4'h7);
        #2 RST = 1'b0;
        #1;
        n_checks++; if (lights !== 4'b0000 || fail_count !== 2'd0 || rd_addr !== 2'd0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got lights=%b fail=%0d rd_addr=%0d wr_en=%b want 0000/0/0/0", lights, fail_count, rd_addr, wr_en);
        end
        @(negedge CLK); RST = 1'b1;
        key4(4'h7, 4'h7, 4'h7, 4'h7);
        n_checks++; if (lights !== 4'b1000) begin n_fail++; $display("FAIL reset_idx_zero: got %b want 1000", lights); end
    endtask

    initial begin
        test_reset();
        test_user_unlock();
        test_error();
        test_lock();
        test_admin();
        test_prog();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
